// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_stage
//  Purpose  : Final pipeline stage. Accepts retiring instructions from the
//             memory stage over a valid/ready handshake. For loads it waits
//             for the data-memory response, then byte-aligns and sign- or
//             zero-extends it. It drives one register-file write pulse per
//             instruction.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             in_valid / in_ready      - upstream handshake
//             in_reg_write, in_rd      - destination control
//             in_wb_sel                - 00 ALU, 01 load, 10 PC+4, 11 imm
//             in_alu_result, in_pc,
//             in_imm, in_funct3        - candidate values / load type
//             mem_rsp_valid/_data      - data-memory load response
//             wrEn, Rdst, RWrdata      - register-file write port (registered)
//             retire                   - one-cycle pulse per completed instr
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [2:0]        in_funct3,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              wrEn,
  output logic [REG_AW-1:0] Rdst,
  output logic [XLEN-1:0]   RWrdata,
  output logic              retire
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t              state_q;
  logic                wrEn_q;
  logic [REG_AW-1:0]   Rdst_q;
  logic [XLEN-1:0]     RWrdata_q;
  logic                retire_q;

  // Context of the load waiting for its memory response
  logic [REG_AW-1:0]   pend_rd_q;
  logic                pend_rw_q;
  logic [2:0]          pend_f3_q;
  logic [1:0]          pend_off_q;

  logic                accept_d;
  logic [XLEN-1:0]     sel_value_d;
  logic [XLEN-1:0]     load_value_d;
  logic [XLEN-1:0]     shifted_d;
  logic [7:0]          byte_d;
  logic [15:0]         half_d;

  assign in_ready = (state_q == RUN);
  assign accept_d = in_valid && in_ready;

  // Non-load write-back value; PC+4 wraps naturally at 2^32
  always_comb begin
    sel_value_d = in_alu_result;
    case (in_wb_sel)
      WB_ALU:  sel_value_d = in_alu_result;
      WB_PC4:  sel_value_d = in_pc + XLEN'(4);
      WB_IMM:  sel_value_d = in_imm;
      default: sel_value_d = in_alu_result;
    endcase
  end

  // Load formatting: byte selected by the full offset, halfword by off[1]
  // only (misalignment is deliberately not checked).
  always_comb begin
    shifted_d    = mem_rsp_data >> {pend_off_q, 3'b000};
    byte_d       = shifted_d[7:0];
    half_d       = pend_off_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    load_value_d = mem_rsp_data;
    case (pend_f3_q)
      F3_LB:   load_value_d = {{(XLEN-8){byte_d[7]}}, byte_d};
      F3_LBU:  load_value_d = {{(XLEN-8){1'b0}}, byte_d};
      F3_LH:   load_value_d = {{(XLEN-16){half_d[15]}}, half_d};
      F3_LHU:  load_value_d = {{(XLEN-16){1'b0}}, half_d};
      default: load_value_d = mem_rsp_data;   // LW and unused encodings
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wrEn_q     <= 1'b0;
      Rdst_q     <= '0;
      RWrdata_q  <= '0;
      retire_q   <= 1'b0;
      pend_rd_q  <= '0;
      pend_rw_q  <= 1'b0;
      pend_f3_q  <= '0;
      pend_off_q <= '0;
    end else begin
      // Pulses by default; re-asserted only when something completes
      wrEn_q   <= 1'b0;
      retire_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept_d) begin
            if (in_wb_sel == WB_LOAD) begin
              pend_rd_q  <= in_rd;
              pend_rw_q  <= in_reg_write;
              pend_f3_q  <= in_funct3;
              pend_off_q <= in_alu_result[1:0];
              state_q    <= WAIT_LOAD;
            end else begin
              Rdst_q    <= in_rd;
              RWrdata_q <= sel_value_d;
              wrEn_q    <= in_reg_write && (in_rd != '0);
              retire_q  <= 1'b1;
            end
          end
          // A memory response here has no pending load and is dropped
        end
        WAIT_LOAD: begin
          if (mem_rsp_valid) begin
            Rdst_q    <= pend_rd_q;
            RWrdata_q <= load_value_d;
            wrEn_q    <= pend_rw_q && (pend_rd_q != '0);
            retire_q  <= 1'b1;
            state_q   <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign wrEn    = wrEn_q;
  assign Rdst    = Rdst_q;
  assign RWrdata = RWrdata_q;
  assign retire  = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_stage
//  Purpose  : Directed, self-checking bench for writeback_stage. Expected
//             register-file writes are queued with the cycle they are due and
//             compared when the stage retires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [2:0]  in_funct3;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wrEn;
  logic [4:0]  Rdst;
  logic [31:0] RWrdata;
  logic        retire;

  writeback_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_funct3     (in_funct3),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .wrEn          (wrEn),
    .Rdst          (Rdst),
    .RWrdata       (RWrdata),
    .retire        (retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic we, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, score any retire
  task automatic cycle();
    exp_t e;
    logic exp_ret;
    @(posedge clk);
    #1;
    cyc++;
    exp_ret = (sb.size() > 0) && (sb[0].due == cyc);
    check("retire", {31'b0, retire}, {31'b0, exp_ret});
    if (exp_ret) begin
      e = sb.pop_front();
      check("wrEn",    {31'b0, wrEn}, {31'b0, e.we});
      check("Rdst",    {27'b0, Rdst}, {27'b0, e.rd});
      check("RWrdata", RWrdata, e.data);
    end else begin
      check("wrEn_idle", {31'b0, wrEn}, 32'h0);
      if ((sb.size() > 0) && (sb[0].due < cyc)) void'(sb.pop_front());
    end
  endtask

  task automatic set_instr(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [2:0] f3);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_rd         = rd;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc         = pc;
    in_imm        = imm;
    in_funct3     = f3;
  endtask

  // Issue a load, hold off the response for 'waits' cycles, then respond
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input int waits,
                         input logic [31:0] rsp, input logic [31:0] exp);
    set_instr(1'b1, rd, 2'b01, addr, 32'h0, 32'h0, f3);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check({tag, "_ready_wait"}, {31'b0, in_ready}, 32'h0);
      cycle();
    end
    check({tag, "_ready_rsp"}, {31'b0, in_ready}, 32'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    expect_wr(1'b1, rd, exp);
    cycle();
    mem_rsp_valid = 1'b0;
    check({tag, "_ready_after"}, {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_rd         = '0;
    in_wb_sel     = '0;
    in_alu_result = '0;
    in_pc         = '0;
    in_imm        = '0;
    in_funct3     = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    cycle();
    cycle();
    check("rst_Rdst",    {27'b0, Rdst}, 32'h0);
    check("rst_RWrdata", RWrdata, 32'h0);
    rst = 1'b0;
    cycle();
    check("rst_ready", {31'b0, in_ready}, 32'h1);

    // Single ALU op
    set_instr(1'b1, 5'd5, 2'b00, 32'h12345678, 32'h0, 32'h0, 3'b000);
    expect_wr(1'b1, 5'd5, 32'h12345678);
    cycle();
    in_valid = 1'b0;
    cycle();

    // Back-to-back ALU ops, in_ready must stay high throughout
    for (int i = 1; i <= 3; i++) begin
      check("b2b_ready", {31'b0, in_ready}, 32'h1);
      set_instr(1'b1, 5'(i), 2'b00, 32'h100 + 32'(i), 32'h0, 32'h0, 3'b000);
      expect_wr(1'b1, 5'(i), 32'h100 + 32'(i));
      cycle();
    end
    in_valid = 1'b0;
    check("b2b_ready_end", {31'b0, in_ready}, 32'h1);
    cycle();

    // Loads with various types and offsets
    do_load("LB",    3'b000, 32'h0000_1003, 5'd10, 4, 32'h80FF_0000, 32'hFFFF_FF80);
    cycle();
    do_load("LBU",   3'b100, 32'h0000_1003, 5'd11, 4, 32'h80FF_0000, 32'h0000_0080);
    cycle();
    do_load("LH",    3'b001, 32'h0000_1002, 5'd12, 4, 32'h80FF_0000, 32'hFFFF_80FF);
    cycle();
    do_load("LHU",   3'b101, 32'h0000_2001, 5'd13, 1, 32'h1234_F00D, 32'h0000_F00D);
    cycle();
    do_load("LB1",   3'b000, 32'h0000_2001, 5'd14, 0, 32'h1234_F00D, 32'hFFFF_FFF0);
    cycle();
    do_load("LW",    3'b010, 32'h0000_2000, 5'd15, 2, 32'h1234_F00D, 32'h1234_F00D);
    cycle();
    do_load("F3_011", 3'b011, 32'h0000_2002, 5'd16, 1, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // New instruction accepted in the same cycle as the load write pulse
    set_instr(1'b1, 5'd7, 2'b00, 32'h0000_0777, 32'h0, 32'h0, 3'b000);
    expect_wr(1'b1, 5'd7, 32'h0000_0777);
    cycle();
    in_valid = 1'b0;
    cycle();

    // rd=0 suppresses the write but still retires
    set_instr(1'b1, 5'd0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 3'b000);
    expect_wr(1'b0, 5'd0, 32'hDEADBEEF);
    cycle();
    // PC+4 wraps
    set_instr(1'b1, 5'd1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b000);
    expect_wr(1'b1, 5'd1, 32'h0000_0000);
    cycle();
    // PC+4 ordinary
    set_instr(1'b1, 5'd2, 2'b10, 32'h5, 32'h0000_1000, 32'h0, 3'b000);
    expect_wr(1'b1, 5'd2, 32'h0000_1004);
    cycle();
    // Immediate path with reg_write=0
    set_instr(1'b0, 5'd9, 2'b11, 32'h5, 32'h0, 32'hABCD_E000, 3'b000);
    expect_wr(1'b0, 5'd9, 32'hABCD_E000);
    cycle();
    // Load with reg_write=0 still retires without a write
    in_valid = 1'b0;
    cycle();
    set_instr(1'b0, 5'd20, 2'b01, 32'h0, 32'h0, 32'h0, 3'b010);
    cycle();
    in_valid      = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0BAD_F00D;
    expect_wr(1'b0, 5'd20, 32'h0BAD_F00D);
    cycle();
    mem_rsp_valid = 1'b0;
    cycle();

    // Reset during a pending load abandons it; late response ignored
    set_instr(1'b1, 5'd21, 2'b01, 32'h0, 32'h0, 32'h0, 3'b010);
    cycle();
    in_valid = 1'b0;
    check("pend_ready", {31'b0, in_ready}, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_ready", {31'b0, in_ready}, 32'h1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1111_2222;
    cycle();
    mem_rsp_valid = 1'b0;
    check("late_rsp_Rdst",    {27'b0, Rdst}, 32'h0);
    check("late_rsp_RWrdata", RWrdata, 32'h0);
    check("late_rsp_ready",   {31'b0, in_ready}, 32'h1);
    cycle();

    // Stray response in RUN is ignored and the stage keeps working
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h3333_4444;
    cycle();
    mem_rsp_valid = 1'b0;
    check("stray_ready", {31'b0, in_ready}, 32'h1);
    set_instr(1'b1, 5'd30, 2'b00, 32'h0000_0030, 32'h0, 32'h0, 3'b000);
    expect_wr(1'b1, 5'd30, 32'h0000_0030);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
